// File: rtl/mj32_pkg.sv
// MJ32 shared decode definitions: opcodes, funct7 patterns, format/class codes, immediate widths.
package mj32_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_ZERO   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam int IMM_I_W = 12;
    localparam int IMM_S_W = 12;
    localparam int IMM_B_W = 13;
    localparam int IMM_U_W = 32;
    localparam int IMM_J_W = 21;

    // FMT_X marks an unrecognised opcode: no register or immediate fields.
    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5,
        FMT_X = 3'd7
    } fmt_e;

    typedef enum logic [3:0] {
        CLS_NONE   = 4'd0,
        CLS_ALU_R  = 4'd1,
        CLS_ALU_I  = 4'd2,
        CLS_LOAD   = 4'd3,
        CLS_STORE  = 4'd4,
        CLS_BRANCH = 4'd5,
        CLS_JAL    = 4'd6,
        CLS_JALR   = 4'd7,
        CLS_LUI    = 4'd8,
        CLS_AUIPC  = 4'd9,
        CLS_MULDIV = 4'd10
    } cls_e;

endpackage

// File: rtl/decode_comb.sv
// Pure combinational RV32I(+M) decoder: instruction word -> format, class, fields, immediate, legality.
module decode_comb
    import mj32_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b0
) (
    input  logic [31:0]     instr,
    output logic [2:0]      fmt,
    output logic [3:0]      cls,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic            rf_we,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    function automatic logic [31:0] imm_i(input logic [31:0] w);
        return {{(32-IMM_I_W){w[31]}}, w[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] w);
        return {{(32-IMM_S_W){w[31]}}, w[31:25], w[11:7]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] w);
        return {{(32-IMM_B_W){w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] w);
        return {w[31:12], 12'd0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] w);
        return {{(32-IMM_J_W){w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    endfunction

    // Widen a 32-bit signed immediate to the datapath width.
    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    logic [6:0]  opcode_s;
    logic [2:0]  f3_s;
    logic [6:0]  f7_s;
    fmt_e        fmt_s;
    cls_e        cls_s;
    logic        legal_s;
    logic        use_rs1_s;
    logic        use_rs2_s;
    logic        use_rd_s;
    logic        use_f3_s;
    logic        use_f7_s;
    logic [31:0] imm32_s;

    assign opcode_s = instr[6:0];
    assign f3_s     = instr[14:12];
    assign f7_s     = instr[31:25];

    // Classify the opcode: pick format, class, which fields exist, immediate and legality.
    always_comb begin
        fmt_s     = FMT_X;
        cls_s     = CLS_NONE;
        legal_s   = 1'b0;
        use_rs1_s = 1'b0;
        use_rs2_s = 1'b0;
        use_rd_s  = 1'b0;
        use_f3_s  = 1'b0;
        use_f7_s  = 1'b0;
        imm32_s   = 32'd0;
        case (opcode_s)
            OP_R: begin
                fmt_s     = FMT_R;
                use_rs1_s = 1'b1;
                use_rs2_s = 1'b1;
                use_rd_s  = 1'b1;
                use_f3_s  = 1'b1;
                use_f7_s  = 1'b1;
                if (f7_s == F7_MULDIV) begin
                    cls_s   = CLS_MULDIV;
                    legal_s = ENABLE_M;
                end else begin
                    cls_s   = CLS_ALU_R;
                    legal_s = (f7_s == F7_ZERO) ||
                              ((f7_s == F7_ALT) && ((f3_s == 3'b000) || (f3_s == 3'b101)));
                end
            end
            OP_I: begin
                fmt_s     = FMT_I;
                cls_s     = CLS_ALU_I;
                use_rs1_s = 1'b1;
                use_rd_s  = 1'b1;
                use_f3_s  = 1'b1;
                imm32_s   = imm_i(instr);
                // Shifts carry a funct7 in the upper immediate bits; only SRAI may use the alt form.
                if (f3_s == 3'b001) begin
                    use_f7_s = 1'b1;
                    legal_s  = (f7_s == F7_ZERO);
                end else if (f3_s == 3'b101) begin
                    use_f7_s = 1'b1;
                    legal_s  = (f7_s == F7_ZERO) || (f7_s == F7_ALT);
                end else begin
                    legal_s  = 1'b1;
                end
            end
            OP_LOAD: begin
                fmt_s     = FMT_I;
                cls_s     = CLS_LOAD;
                use_rs1_s = 1'b1;
                use_rd_s  = 1'b1;
                use_f3_s  = 1'b1;
                imm32_s   = imm_i(instr);
                legal_s   = (f3_s != 3'b011) && (f3_s != 3'b110) && (f3_s != 3'b111);
            end
            OP_STORE: begin
                fmt_s     = FMT_S;
                cls_s     = CLS_STORE;
                use_rs1_s = 1'b1;
                use_rs2_s = 1'b1;
                use_f3_s  = 1'b1;
                imm32_s   = imm_s(instr);
                legal_s   = (f3_s <= 3'b010);
            end
            OP_BRANCH: begin
                fmt_s     = FMT_B;
                cls_s     = CLS_BRANCH;
                use_rs1_s = 1'b1;
                use_rs2_s = 1'b1;
                use_f3_s  = 1'b1;
                imm32_s   = imm_b(instr);
                legal_s   = (f3_s != 3'b010) && (f3_s != 3'b011);
            end
            OP_JAL: begin
                fmt_s    = FMT_J;
                cls_s    = CLS_JAL;
                use_rd_s = 1'b1;
                imm32_s  = imm_j(instr);
                legal_s  = 1'b1;
            end
            OP_JALR: begin
                fmt_s     = FMT_I;
                cls_s     = CLS_JALR;
                use_rs1_s = 1'b1;
                use_rd_s  = 1'b1;
                use_f3_s  = 1'b1;
                imm32_s   = imm_i(instr);
                legal_s   = (f3_s == 3'b000);
            end
            OP_LUI: begin
                fmt_s    = FMT_U;
                cls_s    = CLS_LUI;
                use_rd_s = 1'b1;
                imm32_s  = imm_u(instr);
                legal_s  = 1'b1;
            end
            OP_AUIPC: begin
                fmt_s    = FMT_U;
                cls_s    = CLS_AUIPC;
                use_rd_s = 1'b1;
                imm32_s  = imm_u(instr);
                legal_s  = 1'b1;
            end
            default: begin
                fmt_s   = FMT_X;
                legal_s = 1'b0;
            end
        endcase
    end

    // Illegal words keep their fields but never claim a class or a register write.
    assign fmt     = fmt_s;
    assign cls     = legal_s ? cls_s : CLS_NONE;
    assign funct3  = use_f3_s  ? f3_s         : 3'd0;
    assign funct7  = use_f7_s  ? f7_s         : 7'd0;
    assign rs1     = use_rs1_s ? instr[19:15] : 5'd0;
    assign rs2     = use_rs2_s ? instr[24:20] : 5'd0;
    assign rd      = use_rd_s  ? instr[11:7]  : 5'd0;
    assign rf_we   = use_rd_s && (instr[11:7] != 5'd0) && legal_s;
    assign imm     = sext32(imm32_s);
    assign illegal = !legal_s;

endmodule

// File: rtl/decode_stage.sv
// MJ32 decode stage: valid/ready handshake around decode_comb with a fully registered output bank.
module decode_stage
    import mj32_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int PC_W     = 32,
    parameter bit ENABLE_M = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [PC_W-1:0] in_pc,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [2:0]      out_fmt,
    output logic [3:0]      out_cls,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic            out_rf_we,
    output logic [XLEN-1:0] out_imm,
    output logic            out_illegal
);

    localparam int DW = 3 + 4 + 3 + 7 + 5 + 5 + 5 + 1 + XLEN + 1;

    logic [2:0]      dec_fmt_s;
    logic [3:0]      dec_cls_s;
    logic [2:0]      dec_funct3_s;
    logic [6:0]      dec_funct7_s;
    logic [4:0]      dec_rs1_s;
    logic [4:0]      dec_rs2_s;
    logic [4:0]      dec_rd_s;
    logic            dec_rf_we_s;
    logic [XLEN-1:0] dec_imm_s;
    logic            dec_illegal_s;
    logic [DW-1:0]   dec_bus_s;
    logic            accept_s;

    logic            valid_d, valid_q;
    logic [PC_W-1:0] pc_d, pc_q;
    logic [DW-1:0]   data_d, data_q;

    decode_comb #(
        .XLEN     (XLEN),
        .ENABLE_M (ENABLE_M)
    ) u_decode (
        .instr   (in_instr),
        .fmt     (dec_fmt_s),
        .cls     (dec_cls_s),
        .funct3  (dec_funct3_s),
        .funct7  (dec_funct7_s),
        .rs1     (dec_rs1_s),
        .rs2     (dec_rs2_s),
        .rd      (dec_rd_s),
        .rf_we   (dec_rf_we_s),
        .imm     (dec_imm_s),
        .illegal (dec_illegal_s)
    );

    assign dec_bus_s = {dec_fmt_s, dec_cls_s, dec_funct3_s, dec_funct7_s, dec_rs1_s,
                        dec_rs2_s, dec_rd_s, dec_rf_we_s, dec_imm_s, dec_illegal_s};

    // Ready depends only on flush and the held slot, never on in_valid/in_pc/in_instr.
    assign in_ready = !flush && (!valid_q || out_ready);
    assign accept_s = in_valid && in_ready;

    // Next-state: flush drops everything, accept loads, consume empties, otherwise hold.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept_s) begin
            valid_d = 1'b1;
            pc_d    = in_pc;
            data_d  = dec_bus_s;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Output register bank; reset clears valid and every data field.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_pc    = pc_q;
    assign {out_fmt, out_cls, out_funct3, out_funct7, out_rs1, out_rs2,
            out_rd, out_rf_we, out_imm, out_illegal} = data_q;

endmodule
